alu_decode_stage: RTL

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/rv32i_pkg.sv | 56 +++++
 rtl/alu_op_decoder.sv | 125 ++++++++++++
 rtl/alu_decode_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: ALU select codes, major opcodes and the decoded control bundle.
// The illegal flag field exists only when ALU_DECODE_ILLEGAL_EN is defined.
package rv32i_pkg;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassB = 4'd10
  } alu_sel_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef struct packed {
    alu_sel_e   alu_sel;
    logic [4:0] rd;
    logic       reg_write;
`ifdef ALU_DECODE_ILLEGAL_EN
    logic       illegal;
`endif
  } dec_ctrl_t;

  // alt selects SUB/SRA over ADD/SRL; ignored for the other funct3 values.
  function automatic alu_sel_e f3_to_alu(input logic [2:0] funct3, input logic alt);
    alu_sel_e sel;
    sel = AluAdd;
    case (funct3)
      3'b000: sel = alt ? AluSub : AluAdd;
      3'b001: sel = AluSll;
      3'b010: sel = AluSlt;
      3'b011: sel = AluSltu;
      3'b100: sel = AluXor;
      3'b101: sel = alt ? AluSra : AluSrl;
      3'b110: sel = AluOr;
      3'b111: sel = AluAnd;
      default: sel = AluAdd;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I decode into ALU select, operands, rd and write enable.
// ALU_DECODE_ILLEGAL_EN adds an illegal flag to the control output.
module alu_op_decoder
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output dec_ctrl_t       ctrl_o,
  output logic [XLEN-1:0] op_a_o,
  output logic [XLEN-1:0] op_b_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = XLEN'($signed(instr_i[31:20]));
  assign imm_s  = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
  assign imm_u  = XLEN'($signed({instr_i[31:12], 12'b0}));
  assign shamt  = XLEN'(instr_i[24:20]);

  always_comb begin
    ctrl_o           = '0;
    ctrl_o.alu_sel   = AluAdd;
    ctrl_o.rd        = instr_i[11:7];
    ctrl_o.reg_write = 1'b0;
    op_a_o           = '0;
    op_b_o           = '0;
    illegal          = 1'b0;

    case (opcode)
      OpcOp: begin
        op_a_o = rs1_data_i;
        op_b_o = rs2_data_i;
        if (funct7 == 7'h00 ||
            (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          ctrl_o.alu_sel   = f3_to_alu(funct3, funct7[5]);
          ctrl_o.reg_write = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OpcOpImm: begin
        op_a_o = rs1_data_i;
        if (funct3 == 3'b001) begin
          op_b_o = shamt;
          if (funct7 == 7'h00) begin
            ctrl_o.alu_sel   = AluSll;
            ctrl_o.reg_write = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else if (funct3 == 3'b101) begin
          op_b_o = shamt;
          if (funct7 == 7'h00 || funct7 == 7'h20) begin
            ctrl_o.alu_sel   = f3_to_alu(funct3, instr_i[30]);
            ctrl_o.reg_write = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          // Immediate forms never use the alternate encoding, so no SUBI.
          op_b_o           = imm_i;
          ctrl_o.alu_sel   = f3_to_alu(funct3, 1'b0);
          ctrl_o.reg_write = 1'b1;
        end
      end
      OpcLui: begin
        ctrl_o.alu_sel   = AluPassB;
        op_b_o           = imm_u;
        ctrl_o.reg_write = 1'b1;
      end
      OpcAuipc: begin
        op_a_o           = pc_i;
        op_b_o           = imm_u;
        ctrl_o.reg_write = 1'b1;
      end
      OpcLoad: begin
        op_a_o           = rs1_data_i;
        op_b_o           = imm_i;
        ctrl_o.reg_write = 1'b1;
      end
      OpcStore: begin
        op_a_o = rs1_data_i;
        op_b_o = imm_s;
      end
      OpcJal, OpcJalr: begin
        // ALU produces the link address; the target is computed elsewhere.
        op_a_o           = pc_i;
        op_b_o           = XLEN'(4);
        ctrl_o.reg_write = 1'b1;
      end
      OpcBranch: begin
        ctrl_o.alu_sel = AluSub;
        op_a_o         = rs1_data_i;
        op_b_o         = rs2_data_i;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      ctrl_o.alu_sel   = AluAdd;
      ctrl_o.reg_write = 1'b0;
    end
    if (ctrl_o.rd == 5'd0) begin
      ctrl_o.reg_write = 1'b0;
    end
`ifdef ALU_DECODE_ILLEGAL_EN
    ctrl_o.illegal = illegal;
`endif
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage: RV32I decode feeding a two-entry (main + skid) ready/valid buffer.
// Defining ALU_DECODE_ILLEGAL_EN adds the illegal output.
module alu_decode_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_sel,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [4:0]      rd,
  output logic            reg_write
`ifdef ALU_DECODE_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  typedef struct packed {
    dec_ctrl_t       ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
  } bundle_t;

  state_e          state_q, state_d;
  bundle_t         main_q, main_d;
  bundle_t         skid_q, skid_d;
  logic            in_ready_q, in_ready_d;
  bundle_t         dec_bundle;
  dec_ctrl_t       dec_ctrl;
  logic [XLEN-1:0] dec_op_a;
  logic [XLEN-1:0] dec_op_b;
  logic            in_fire;
  logic            out_fire;

  alu_op_decoder #(
    .XLEN(XLEN)
  ) u_dec (
    .instr_i   (instr),
    .pc_i      (pc),
    .rs1_data_i(rs1_data),
    .rs2_data_i(rs2_data),
    .ctrl_o    (dec_ctrl),
    .op_a_o    (dec_op_a),
    .op_b_o    (dec_op_b)
  );

  assign dec_bundle = '{ctrl: dec_ctrl, op_a: dec_op_a, op_b: dec_op_b};

  assign out_valid = (state_q != StEmpty);
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = dec_bundle;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_d = dec_bundle;
        end else if (in_fire) begin
          skid_d  = dec_bundle;
          state_d = StTwo;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // in_ready is low here, so only the drain of main can happen.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign alu_sel   = main_q.ctrl.alu_sel;
  assign op_a      = main_q.op_a;
  assign op_b      = main_q.op_b;
  assign rd        = main_q.ctrl.rd;
  assign reg_write = main_q.ctrl.reg_write;
`ifdef ALU_DECODE_ILLEGAL_EN
  assign illegal   = main_q.ctrl.illegal;
`endif

endmodule
